// File: rtl/b01_deser.sv
`default_nettype none
// ============================================================================
// Module   : b01_deser
// Brief    : Serial-to-parallel deserializer for the flow-comparator bit stream,
//            with per-word overflow tally and a one-word output holding stage.
// Revision : 1.0 - initial release
// ============================================================================
module b01_deser #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         nRESET_G,
   input  logic         BIT_VALID,
   input  logic         OUTP_IN,
   input  logic         OVERFLW_IN,
   input  logic         DATA_READY,
   output logic [W-1:0] DATA_OUT,
   output logic [4:0]   OVF_CNT,
   output logic         DATA_VALID,
   output logic         DROP_ERR
);

   localparam int CNT_W = $clog2(W);
   localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(W - 1);

   localparam logic [0:0] S_EMPTY = 1'b0;
   localparam logic [0:0] S_FULL  = 1'b1;

   logic [0:0]       r_state;
   logic [W-1:0]     r_shift;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [4:0]       r_ovf_acc;
   logic [W-1:0]     r_data_out;
   logic [4:0]       r_ovf_out;
   logic             r_drop_err;

   logic             w_word_done;
   logic [W-1:0]     w_shift_next;
   logic [4:0]       w_ovf_next;

   assign w_word_done  = BIT_VALID && (r_bit_cnt == C_LAST_BIT);
   assign w_shift_next = {r_shift[W-2:0], OUTP_IN};
   assign w_ovf_next   = r_ovf_acc + {4'd0, OVERFLW_IN};

   // Collection path: only qualified bits touch the shift/count state.
   always_ff @(posedge clock or negedge nRESET_G) begin
      if (!nRESET_G) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_ovf_acc <= '0;
      end else if (BIT_VALID) begin
         r_shift <= w_shift_next;
         if (w_word_done) begin
            r_bit_cnt <= '0;
            r_ovf_acc <= '0;
         end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_ovf_acc <= w_ovf_next;
         end
      end
   end

   // Output holding stage: a completed word is loaded when the slot is empty
   // or being drained on the same edge, otherwise it is dropped.
   always_ff @(posedge clock or negedge nRESET_G) begin
      if (!nRESET_G) begin
         r_state    <= S_EMPTY;
         r_data_out <= '0;
         r_ovf_out  <= '0;
         r_drop_err <= 1'b0;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_word_done) begin
                  r_data_out <= w_shift_next;
                  r_ovf_out  <= w_ovf_next;
                  r_state    <= S_FULL;
               end
            end
            S_FULL: begin
               if (w_word_done) begin
                  if (DATA_READY) begin
                     r_data_out <= w_shift_next;
                     r_ovf_out  <= w_ovf_next;
                  end else begin
                     r_drop_err <= 1'b1;
                  end
               end else if (DATA_READY) begin
                  r_state <= S_EMPTY;
               end
            end
            default: r_state <= S_EMPTY;
         endcase
      end
   end

   assign DATA_OUT   = r_data_out;
   assign OVF_CNT    = r_ovf_out;
   assign DATA_VALID = (r_state == S_FULL);
   assign DROP_ERR   = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_b01_deser.sv
`default_nettype none
// Directed testbench for b01_deser (W=8): one task per scenario, inline checks.
module tb_b01_deser;

   logic       clock;
   logic       nRESET_G;
   logic       BIT_VALID;
   logic       OUTP_IN;
   logic       OVERFLW_IN;
   logic       DATA_READY;
   logic [7:0] DATA_OUT;
   logic [4:0] OVF_CNT;
   logic       DATA_VALID;
   logic       DROP_ERR;

   int checks = 0;
   int errors = 0;

   b01_deser #(.W(8)) dut (
      .clock      (clock),
      .nRESET_G   (nRESET_G),
      .BIT_VALID  (BIT_VALID),
      .OUTP_IN    (OUTP_IN),
      .OVERFLW_IN (OVERFLW_IN),
      .DATA_READY (DATA_READY),
      .DATA_OUT   (DATA_OUT),
      .OVF_CNT    (OVF_CNT),
      .DATA_VALID (DATA_VALID),
      .DROP_ERR   (DROP_ERR)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One qualified bit sampled on the next rising edge; returns 1 after it.
   task automatic drive_bit(input logic b, input logic ovf, input logic rdy);
      @(negedge clock);
      BIT_VALID  = 1'b1;
      OUTP_IN    = b;
      OVERFLW_IN = ovf;
      DATA_READY = rdy;
      @(posedge clock);
      #1;
      BIT_VALID  = 1'b0;
   endtask

   task automatic idle(input logic rdy);
      @(negedge clock);
      BIT_VALID  = 1'b0;
      OUTP_IN    = 1'b1;
      OVERFLW_IN = 1'b1;
      DATA_READY = rdy;
      @(posedge clock);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] w, input logic [7:0] ovf,
                            input int nbits, input logic rdy);
      for (int i = 7; i > 7 - nbits; i--) drive_bit(w[i], ovf[i], rdy);
   endtask

   task automatic test_reset;
      BIT_VALID = 0; OUTP_IN = 0; OVERFLW_IN = 0; DATA_READY = 0;
      nRESET_G = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++; if (DATA_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", DATA_VALID); end
      checks++; if (DATA_OUT !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", DATA_OUT); end
      checks++; if (OVF_CNT !== 5'd0) begin errors++; $display("FAIL reset_ovf got %0d exp 0", OVF_CNT); end
      checks++; if (DROP_ERR !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", DROP_ERR); end
      @(negedge clock);
      nRESET_G = 1'b1;
   endtask

   task automatic test_basic;
      send_bits(8'hB2, 8'h00, 7, 1'b1);
      checks++; if (DATA_VALID !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", DATA_VALID); end
      drive_bit(1'b0, 1'b0, 1'b1);
      checks++; if (DATA_VALID !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", DATA_VALID); end
      checks++; if (DATA_OUT !== 8'hB2) begin errors++; $display("FAIL basic_data got %h exp b2", DATA_OUT); end
      checks++; if (OVF_CNT !== 5'd0) begin errors++; $display("FAIL basic_ovf got %0d exp 0", OVF_CNT); end
      idle(1'b1);
      checks++; if (DATA_VALID !== 1'b0) begin errors++; $display("FAIL basic_consumed got %b exp 0", DATA_VALID); end
      checks++; if (DATA_OUT !== 8'hB2) begin errors++; $display("FAIL basic_hold_after got %h exp b2", DATA_OUT); end
   endtask

   task automatic test_gapped;
      logic [7:0] w;
      logic [7:0] m;
      w = 8'hB2;
      m = 8'b0010_0010; // 3rd and 7th bits received
      for (int i = 7; i >= 0; i--) begin
         drive_bit(w[i], m[i], 1'b0);
         if (i != 0) idle(1'b0);
         if (i == 1) begin
            checks++; if (DATA_VALID !== 1'b0) begin errors++; $display("FAIL gap_early_valid got %b exp 0", DATA_VALID); end
         end
      end
      checks++; if (DATA_VALID !== 1'b1) begin errors++; $display("FAIL gap_valid got %b exp 1", DATA_VALID); end
      checks++; if (DATA_OUT !== 8'hB2) begin errors++; $display("FAIL gap_data got %h exp b2", DATA_OUT); end
      checks++; if (OVF_CNT !== 5'd2) begin errors++; $display("FAIL gap_ovf got %0d exp 2", OVF_CNT); end
      idle(1'b1);
   endtask

   task automatic test_back_to_back;
      send_bits(8'hA5, 8'h00, 8, 1'b0);
      checks++; if (DATA_OUT !== 8'hA5 || DATA_VALID !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b exp a5/1", DATA_OUT, DATA_VALID); end
      send_bits(8'h3C, 8'h00, 7, 1'b0);
      checks++; if (DATA_OUT !== 8'hA5 || DATA_VALID !== 1'b1) begin errors++; $display("FAIL b2b_hold got %h/%b exp a5/1", DATA_OUT, DATA_VALID); end
      drive_bit(1'b0, 1'b0, 1'b1);
      checks++; if (DATA_VALID !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", DATA_VALID); end
      checks++; if (DATA_OUT !== 8'h3C) begin errors++; $display("FAIL b2b_data got %h exp 3c", DATA_OUT); end
      checks++; if (DROP_ERR !== 1'b0) begin errors++; $display("FAIL b2b_drop got %b exp 0", DROP_ERR); end
      idle(1'b1);
      checks++; if (DATA_VALID !== 1'b0) begin errors++; $display("FAIL b2b_consumed got %b exp 0", DATA_VALID); end
   endtask

   task automatic test_drop;
      send_bits(8'h11, 8'h00, 8, 1'b0);
      checks++; if (DATA_OUT !== 8'h11 || DROP_ERR !== 1'b0) begin errors++; $display("FAIL drop_first got %h/%b exp 11/0", DATA_OUT, DROP_ERR); end
      send_bits(8'h22, 8'hFF, 8, 1'b0);
      checks++; if (DATA_OUT !== 8'h11) begin errors++; $display("FAIL drop_held got %h exp 11", DATA_OUT); end
      checks++; if (OVF_CNT !== 5'd0) begin errors++; $display("FAIL drop_ovf_held got %0d exp 0", OVF_CNT); end
      checks++; if (DROP_ERR !== 1'b1) begin errors++; $display("FAIL drop_flag got %b exp 1", DROP_ERR); end
      checks++; if (DATA_VALID !== 1'b1) begin errors++; $display("FAIL drop_valid got %b exp 1", DATA_VALID); end
      idle(1'b1);
      send_bits(8'h33, 8'h00, 8, 1'b0);
      checks++; if (DATA_OUT !== 8'h33 || DATA_VALID !== 1'b1) begin errors++; $display("FAIL drop_next got %h/%b exp 33/1", DATA_OUT, DATA_VALID); end
      checks++; if (OVF_CNT !== 5'd0) begin errors++; $display("FAIL drop_next_ovf got %0d exp 0", OVF_CNT); end
      checks++; if (DROP_ERR !== 1'b1) begin errors++; $display("FAIL drop_sticky got %b exp 1", DROP_ERR); end
      idle(1'b0);
      checks++; if (DATA_OUT !== 8'h33 || DATA_VALID !== 1'b1) begin errors++; $display("FAIL drop_stall got %h/%b exp 33/1", DATA_OUT, DATA_VALID); end
   endtask

   task automatic test_reset_mid;
      // A held word (0x33) and sticky DROP_ERR are still present here.
      send_bits(8'hF8, 8'hFF, 5, 1'b0);
      #2;
      nRESET_G = 1'b0;
      #1;
      checks++; if (DATA_VALID !== 1'b0 || DATA_OUT !== 8'h00) begin errors++; $display("FAIL rstmid_out got %b/%h exp 0/00", DATA_VALID, DATA_OUT); end
      checks++; if (OVF_CNT !== 5'd0 || DROP_ERR !== 1'b0) begin errors++; $display("FAIL rstmid_flags got %0d/%b exp 0/0", OVF_CNT, DROP_ERR); end
      #1;
      nRESET_G = 1'b1;
      send_bits(8'hFF, 8'h00, 7, 1'b0);
      checks++; if (DATA_VALID !== 1'b0) begin errors++; $display("FAIL rstmid_residue got %b exp 0", DATA_VALID); end
      drive_bit(1'b1, 1'b0, 1'b0);
      checks++; if (DATA_OUT !== 8'hFF || DATA_VALID !== 1'b1) begin errors++; $display("FAIL rstmid_word got %h/%b exp ff/1", DATA_OUT, DATA_VALID); end
      checks++; if (OVF_CNT !== 5'd0) begin errors++; $display("FAIL rstmid_ovf got %0d exp 0", OVF_CNT); end
      idle(1'b1);
   endtask

   task automatic test_ovf_sat;
      send_bits(8'h5A, 8'hFF, 8, 1'b0);
      checks++; if (OVF_CNT !== 5'd8 || DATA_OUT !== 8'h5A) begin errors++; $display("FAIL sat_full got %0d/%h exp 8/5a", OVF_CNT, DATA_OUT); end
      idle(1'b1);
      send_bits(8'h00, 8'h00, 8, 1'b0);
      checks++; if (OVF_CNT !== 5'd0 || DATA_OUT !== 8'h00) begin errors++; $display("FAIL sat_clear got %0d/%h exp 0/00", OVF_CNT, DATA_OUT); end
      checks++; if (DATA_VALID !== 1'b1) begin errors++; $display("FAIL sat_valid got %b exp 1", DATA_VALID); end
      idle(1'b1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gapped();
      test_back_to_back();
      test_drop();
      test_reset_mid();
      test_ovf_sat();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
